combo_lock_fsm: RTL and testbench

//  Six-digit combination-lock controller; the producer end of the lock display path.

---
 rtl/lock_pkg.sv | 13 +
 rtl/cycle_timer.sv | 18 +
 rtl/combo_lock_fsm.sv | 68 ++++++
 tb/tb_combo_lock_fsm.sv | 123 ++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// lock_pkg: state encodings shared with the display decoder, digit width, code-digit helper
package lock_pkg;
  localparam int DIGIT_W = 4;
  typedef enum logic [3:0] {
    SA = 4'd0, SB = 4'd1, SC = 4'd2, SD = 4'd3, SE = 4'd4, SF = 4'd5, SG = 4'd6,
    DCA = 4'd7, DCB = 4'd8, DCC = 4'd9, DCD = 4'd10, DCE = 4'd11, DCF = 4'd12
  } lock_state_t;
  function automatic logic [DIGIT_W-1:0] code_digit(input logic [23:0] code, input logic [3:0] k);
    logic [23:0] s;
    s = code << {k, 2'b00};
    return s[23:20];
  endfunction
endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: loadable down-counter that stops at zero
module cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/combo_lock_fsm.sv
// combo_lock_fsm: six-digit combination lock with auto-relock and lockout timers
module combo_lock_fsm
  import lock_pkg::*;
#(
  parameter logic [23:0] CODE           = 24'h123456,
  parameter int          RELOCK_CYCLES  = 50_000_000,
  parameter int          MAX_FAILS      = 3,
  parameter int          LOCKOUT_CYCLES = 250_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               enter,
  output logic [3:0]         state,
  output logic [DIGIT_W-1:0] digit,
  output logic               open,
  output logic               locked_out,
  output logic [2:0]         fail_cnt
);
  localparam int TMAX = RELOCK_CYCLES > LOCKOUT_CYCLES ? RELOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
  lock_state_t st, nxt;
  logic enter_q, accept, valid, tmr_zero, enter_sg, enter_dcf;
  logic [2:0] fail_new;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= SA;
    else st <= nxt;
  always_comb begin
    accept = enter & ~enter_q & ~locked_out;
    valid = accept & (digit_in <= 4'd9);
    nxt = st;
    case (st)
      SA, SB, SC, SD, SE, SF:
        if (valid) nxt = digit_in == code_digit(CODE, st) ? lock_state_t'(st + 4'd1) : lock_state_t'(st + 4'd7);
      SG: if (tmr_zero | valid) nxt = SA;
      DCA, DCB, DCC, DCD, DCE: if (valid) nxt = lock_state_t'(st + 4'd1);
      DCF: if (locked_out ? tmr_zero : valid) nxt = SA;
      default: nxt = SA;
    endcase
  end
  assign enter_sg = nxt == SG && st != SG;
  assign enter_dcf = nxt == DCF && st != DCF;
  assign fail_new = fail_cnt == 3'(MAX_FAILS) ? fail_cnt : fail_cnt + 3'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      digit <= '0;
      open <= 1'b0;
      locked_out <= 1'b0;
      fail_cnt <= '0;
      enter_q <= 1'b0;
    end else begin
      digit <= digit_in;
      enter_q <= enter;
      open <= nxt == SG;
      locked_out <= (enter_dcf && fail_new == 3'(MAX_FAILS)) ? 1'b1 : locked_out & ~tmr_zero;
      fail_cnt <= enter_sg || (locked_out && tmr_zero) ? 3'd0 : enter_dcf ? fail_new : fail_cnt;
    end
  // relock and lockout never overlap, so one counter serves both
  cycle_timer #(.W(TW)) u_tmr (
    .clk(clk),
    .rst_n(rst_n),
    .load(enter_sg | (enter_dcf && fail_new == 3'(MAX_FAILS))),
    .load_val(enter_sg ? TW'(RELOCK_CYCLES - 1) : TW'(LOCKOUT_CYCLES - 1)),
    .en(st == SG | locked_out),
    .zero(tmr_zero)
  );
  assign state = st;
endmodule

// File: tb/tb_combo_lock_fsm.sv
// tb_combo_lock_fsm: directed checks of the combination lock with short timers
module tb_combo_lock_fsm;
  logic clk = 0, rst_n = 0, enter = 0, open, locked_out;
  logic [3:0] digit_in = 0, state, digit;
  logic [2:0] fail_cnt;
  int checks = 0, failures = 0;
  combo_lock_fsm #(.CODE(24'h123456), .RELOCK_CYCLES(8), .MAX_FAILS(2), .LOCKOUT_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .enter(enter), .state(state),
    .digit(digit), .open(open), .locked_out(locked_out), .fail_cnt(fail_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic press(input logic [3:0] d);
    digit_in = d;
    enter = 1;
    @(negedge clk);
    enter = 0;
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 0;
    #2 rst_n = 1;
    @(negedge clk);
  endtask
  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    logic [3:0] seq [6];
    logic [3:0] exp_st [6];
    @(negedge clk);
    do_reset();
    chk("rst_state", state, 0);
    chk("rst_digit", digit, 0);
    chk("rst_open", open, 0);
    chk("rst_lock", locked_out, 0);
    chk("rst_fail", fail_cnt, 0);
    for (int i = 0; i < 6; i++) begin
      press(4'(i + 1));
      chk("ok_state", state, i + 1);
      chk("ok_digit", digit, i + 1);
    end
    chk("open_hi", open, 1);
    ticks(6);
    chk("relock_hold", state, 6);
    chk("relock_open_hold", open, 1);
    ticks(1);
    chk("relock_state", state, 0);
    chk("relock_open", open, 0);
    seq = '{4'd1, 4'd9, 4'd3, 4'd4, 4'd5, 4'd6};
    exp_st = '{4'd1, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
    for (int i = 0; i < 6; i++) begin
      press(seq[i]);
      chk("wrong_state", state, exp_st[i]);
    end
    chk("wrong_fail", fail_cnt, 1);
    chk("wrong_lock", locked_out, 0);
    press(4'd1);
    chk("dcf_exit", state, 0);
    chk("dcf_fail_kept", fail_cnt, 1);
    digit_in = 1;
    enter = 1;
    ticks(20);
    chk("held_state", state, 1);
    enter = 0;
    ticks(1);
    do_reset();
    press(4'hA);
    chk("bad_digit_state", state, 0);
    chk("bad_digit_digit", digit, 4'hA);
    chk("bad_digit_fail", fail_cnt, 0);
    for (int i = 0; i < 6; i++) press(4'd9);
    chk("lo1_state", state, 12);
    chk("lo1_fail", fail_cnt, 1);
    press(4'd1);
    for (int i = 0; i < 6; i++) press(4'd9);
    chk("lo2_fail", fail_cnt, 2);
    chk("lo2_lock", locked_out, 1);
    for (int i = 0; i < 4; i++) begin
      press(4'd1);
      chk("lo_hold_state", state, 12);
      chk("lo_hold_lock", locked_out, 1);
    end
    digit_in = 1;
    enter = 1;
    ticks(1);
    chk("lo_end_state", state, 0);
    chk("lo_end_lock", locked_out, 0);
    chk("lo_end_fail", fail_cnt, 0);
    enter = 0;
    ticks(1);
    chk("lo_edge_dropped", state, 0);
    do_reset();
    press(4'd1);
    press(4'd2);
    press(4'd3);
    chk("sd_state", state, 3);
    rst_n = 0;
    #1 chk("async_rst_state", state, 0);
    chk("async_rst_digit", digit, 0);
    #1 rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) press(4'(i + 1));
    chk("sg_again", state, 6);
    ticks(6);
    digit_in = 1;
    enter = 1;
    ticks(1);
    chk("expiry_edge_state", state, 0);
    chk("expiry_edge_open", open, 0);
    enter = 0;
    ticks(1);
    chk("expiry_edge_after", state, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
